// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer of the UART peripheral.
// Ports: uart_clk, rstN (async, active-low); cfg_baud = uart_clk
//   cycles per bit; rx_en enables reception; rxd is the async serial
//   input; rx_data/rx_valid/rx_ready form the word handshake;
//   frame_err/parity_err/overrun_err are sticky until err_clr;
//   busy is high while a frame is in progress.
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS   = 8,
    parameter bit          PARITY_EN   = 1'b0,
    parameter bit          PARITY_ODD  = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 uart_clk,
    input  logic                 rstN,
    input  logic [31:0]          cfg_baud,
    input  logic                 rx_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    input  logic                 err_clr,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    logic [31:0]            tick_div;
    logic [31:0]            tick_cnt;
    logic                   tick;
    logic [3:0]             sample_cnt;
    logic                   mid_start;
    logic                   mid_bit;

    logic [DATA_BITS-1:0]   shreg;
    logic [3:0]             bit_cnt;
    logic                   last_bit;
    logic                   perr_pend;
    logic                   par_exp;

    logic                   shift_en;
    logic                   par_chk;
    logic                   done;
    logic                   accept;
    logic                   load;

    // ---------------------------------------------------------------
    // rxd synchronizer; stages reset to the idle (high) line level
    // ---------------------------------------------------------------
    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------
    // 16x oversampling tick, aligned to the start edge because the
    // counter is held at zero while idle
    // ---------------------------------------------------------------
    always_comb begin
        tick_div = cfg_baud >> 4;
        if (tick_div == 32'd0) begin
            tick_div = 32'd1;
        end
    end

    // >= rather than == so a live shrink of cfg_baud cannot strand
    // the counter above its new terminal value
    assign tick = (state_q != S_IDLE) &&
                  (tick_cnt >= tick_div - 32'd1);

    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            tick_cnt <= 32'd0;
        end else if (state_q == S_IDLE || tick) begin
            tick_cnt <= 32'd0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    assign mid_start = tick && (sample_cnt == 4'd7);
    assign mid_bit   = tick && (sample_cnt == 4'd15);

    // Restarted at mid start bit so every later bit is sampled at
    // its centre, 16 ticks apart.
    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            sample_cnt <= 4'd0;
        end else if (state_q == S_IDLE) begin
            sample_cnt <= 4'd0;
        end else if (state_q == S_START && mid_start) begin
            sample_cnt <= 4'd0;
        end else if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_bit = (bit_cnt == 4'(DATA_BITS - 1));

    // ---------------------------------------------------------------
    // Frame FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && !rx_en) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_en && !rxs) begin
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (mid_start) begin
                        state_d = rxs ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (mid_bit && last_bit) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (mid_bit) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    // leave at mid stop bit so a back-to-back start
                    // edge is not missed
                    if (mid_bit) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        busy     = (state_q != S_IDLE);
        shift_en = 1'b0;
        par_chk  = 1'b0;
        done     = 1'b0;
        if (rx_en) begin
            unique case (state_q)
                S_DATA:   shift_en = mid_bit;
                S_PARITY: par_chk  = mid_bit;
                S_STOP:   done     = mid_bit;
                default:  ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Data path: shift register, bit count, parity check
    // ---------------------------------------------------------------
    assign par_exp = (^shreg) ^ PARITY_ODD;

    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            shreg     <= '0;
            bit_cnt   <= 4'd0;
            perr_pend <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                bit_cnt   <= 4'd0;
                perr_pend <= 1'b0;
            end
            if (shift_en) begin
                // LSB arrives first and ends up at bit 0
                shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (par_chk && (rxs != par_exp)) begin
                perr_pend <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output handshake
    // ---------------------------------------------------------------
    assign accept = rx_valid && rx_ready;
    assign load   = done && (!rx_valid || accept);

    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (load) begin
            // a new word replaces one accepted in the same cycle
            rx_data  <= shreg;
            rx_valid <= 1'b1;
        end else if (accept) begin
            rx_valid <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Sticky error flags; a set beats a coincident clear
    // ---------------------------------------------------------------
    always_ff @(posedge uart_clk or negedge rstN) begin
        if (!rstN) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (done && !rxs) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (done && perr_pend) begin
                parity_err <= 1'b1;
            end else if (err_clr) begin
                parity_err <= 1'b0;
            end
            if (done && rx_valid && !rx_ready) begin
                overrun_err <= 1'b1;
            end else if (err_clr) begin
                overrun_err <= 1'b0;
            end
        end
    end

endmodule
